cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/halt sequencer for the single-cycle MIPS core and its performance counters.
- Decodes syscalls: print-service syscalls continue, exit stops, any other code pauses until the operator resumes.
- Supports operator single-step.
- Drives the PC/register-write enable and the cycle-counter enable, and counts pauses.

Parameters:
- PRINT_CODE, 34, R1 value for a print syscall; execution continues.
- EXIT_CODE, 10, R1 value for an exit syscall; permanent stop until clr.
- CNT_W, 32, width of pause_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- syscall  in  1  current instruction is SYSCALL (decoder output).
- r1  in  32  current value of the syscall service register.
- go  in  1  resume button, level, already synchronised; rising edge used.
- step_mode  in  1  switch: 1 = single-step operation.
- step  in  1  step button, level, already synchronised; rising edge used.
- cpu_en  out  1  instruction commit enable (PC, regfile, memory write).
- cycle_en  out  1  enable for the cycle counter; equal to cpu_en.
- print_strobe  out  1  one-cycle pulse when a print syscall commits.
- halted  out  1  state is PAUSE or DONE.
- done  out  1  state is DONE.
- state  out  2  RUN=0, STEP=1, PAUSE=2, DONE=3.
- pause_cnt  out  CNT_W  number of entries into PAUSE.

Behaviour:
- Reset: state=RUN, go_q=0, step_q=0, pause_cnt=0.
- Reset outputs: halted=0, done=0; cpu_en=1 unless halt_req is asserted in that cycle.
- Reset is asynchronous and may arrive in any state, mid-pause or mid-step; it forces RUN immediately.
- Edge detect:
  - go_rise = go & ~go_q; step_rise = step & ~step_q.
  - go_q and step_q are registered every cycle in all states.
- halt_req = syscall & (r1 != PRINT_CODE). exit_req = syscall & (r1 == EXIT_CODE).
- cpu_en (combinational):
  - RUN: ~halt_req.
  - STEP: step_rise & ~halt_req.
  - PAUSE: go_rise. This commits the pending syscall so the PC advances past it.
  - DONE: 0.
- print_strobe = cpu_en & syscall & (r1 == PRINT_CODE).
- Transitions, evaluated on each rising clk edge:
  - RUN:
    - exit_req → DONE.
    - else halt_req → PAUSE, and pause_cnt += 1.
    - else step_mode → STEP.
    - else stay in RUN.
  - STEP:
    - exit_req → DONE.
    - else halt_req → PAUSE, and pause_cnt += 1.
    - else ~step_mode → RUN.
    - else stay in STEP.
  - PAUSE:
    - go_rise → STEP if step_mode, else RUN.
    - else stay in PAUSE.
  - DONE: stay in DONE; only clr leaves it.
- Priority:
  - exit beats pause.
  - A halt beats a step_mode change in the same cycle.
  - step_rise coinciding with halt_req in STEP does not commit; the FSM enters PAUSE.
- In PAUSE, step_rise is ignored; only go resumes.
- A go held high across the pause entry does not resume; a fresh 0→1 edge is required.
- pause_cnt:
  - Increments exactly once per PAUSE entry.
  - Wraps modulo 2^CNT_W.
  - Not incremented on DONE entry.
- halted, done and state are pure decodes of the state register; no extra latency.
- A print syscall in RUN commits with no stall.

Test Plan:
- clr pulse, step_mode=0, syscall=0 for 10 cycles → state=0, cpu_en=1 every cycle, pause_cnt=0, print_strobe never asserted.
- syscall=1, r1=34 for 1 cycle in RUN → cpu_en=1, print_strobe=1 for that cycle, state stays 0.
- syscall=1, r1=5 held →
  - cpu_en=0 and next state=2, halted=1, pause_cnt=1.
  - go held high from before the pause does nothing.
  - go 0→1 → cpu_en=1 in that cycle, then state=0.
- syscall=1, r1=10 → state=3, done=1, cpu_en=0 permanently despite go/step edges; clr asynchronously returns state=0.
- step_mode=1 →
  - state=1 after one cycle.
  - cpu_en is 1 only in cycles with a step rising edge: 3 step presses give exactly 3 commit cycles.
  - step held high gives 1 commit.
- In STEP, a step edge coincident with syscall r1=7 → no commit, state=2, pause_cnt increments.
- Force pause_cnt=2^CNT_W−1 (CNT_W=4, 15 pauses) then one more pause → pause_cnt=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle MIPS core: syscall decode, operator
// single-step and resume, commit/cycle-counter enables, and a pause counter.
module cpu_run_ctrl #(
  parameter int unsigned PRINT_CODE = 34,
  parameter int unsigned EXIT_CODE  = 10,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             syscall,
  input  logic [31:0]      r1,
  input  logic             go,
  input  logic             step_mode,
  input  logic             step,
  output logic             cpu_en,
  output logic             cycle_en,
  output logic             print_strobe,
  output logic             halted,
  output logic             done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pause_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0]      PRINT_VAL = 32'(PRINT_CODE);
  localparam logic [31:0]      EXIT_VAL  = 32'(EXIT_CODE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             go_q, go_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] pause_cnt_q, pause_cnt_d;

  logic is_print, halt_req, exit_req, go_rise, step_rise;

  assign is_print  = syscall & (r1 == PRINT_VAL);
  assign halt_req  = syscall & (r1 != PRINT_VAL);
  assign exit_req  = syscall & (r1 == EXIT_VAL);
  assign go_rise   = go & ~go_q;
  assign step_rise = step & ~step_q;
  assign go_d      = go;
  assign step_d    = step;

  // In PAUSE the go edge commits the pending syscall so the PC moves past it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cpu_en = 1'b0;
    unique case (state_q)
      S_RUN:   cpu_en = ~halt_req;
      S_STEP:  cpu_en = step_rise & ~halt_req;
      S_PAUSE: cpu_en = go_rise;
      S_DONE:  cpu_en = 1'b0;
      default: cpu_en = 1'b0;
    endcase
  end

  // Exit outranks pause, and any halt outranks a step_mode change.
  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    unique case (state_q)
      S_RUN, S_STEP: begin
        if (exit_req) begin
          state_d = S_DONE;
        end else if (halt_req) begin
          state_d     = S_PAUSE;
          pause_cnt_d = pause_cnt_q + CNT_ONE;
        end else if (state_q == S_RUN && step_mode) begin
          state_d = S_STEP;
        end else if (state_q == S_STEP && !step_mode) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (go_rise) state_d = step_mode ? S_STEP : S_RUN;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_RUN;
      go_q        <= 1'b0;
      step_q      <= 1'b0;
      pause_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
      state_q     <= state_d;
      go_q        <= go_d;
      step_q      <= step_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  assign cycle_en     = cpu_en;
  assign print_strobe = cpu_en & is_print;
  assign halted       = (state_q == S_PAUSE) | (state_q == S_DONE);
  assign done         = (state_q == S_DONE);
  assign state        = state_q;
  assign pause_cnt    = pause_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a behavioural model predicts each cycle's
// outputs when stimulus is applied; the prediction is popped and compared mid-cycle.
module tb_cpu_run_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          syscall = 1'b0;
  logic [31:0]   r1 = '0;
  logic          go = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          cpu_en, cycle_en, print_strobe, halted, done;
  logic [1:0]    state;
  logic [CW-1:0] pause_cnt;

  cpu_run_ctrl #(.PRINT_CODE(34), .EXIT_CODE(10), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .syscall(syscall), .r1(r1), .go(go),
    .step_mode(step_mode), .step(step), .cpu_en(cpu_en), .cycle_en(cycle_en),
    .print_strobe(print_strobe), .halted(halted), .done(done), .state(state),
    .pause_cnt(pause_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic          cyc;
    logic          ps;
    logic          halted;
    logic          done;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_o;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [1:0]    m_state = 2'd0;
  logic          m_go_q = 1'b0, m_step_q = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  function automatic obs_t obs();
    return '{cpu_en, cycle_en, print_strobe, halted, done, state, pause_cnt};
  endfunction

  function automatic obs_t model_out();
    logic hreq, grise, srise, en;
    hreq  = syscall && (r1 != 32'd34);
    grise = go && !m_go_q;
    srise = step && !m_step_q;
    case (m_state)
      2'd0:    en = !hreq;
      2'd1:    en = srise && !hreq;
      2'd2:    en = grise;
      default: en = 1'b0;
    endcase
    return '{en, en, en && syscall && (r1 == 32'd34), m_state[1], m_state == 2'd3, m_state, m_cnt};
  endfunction

  task automatic model_edge();
    logic hreq, xreq, grise;
    hreq  = syscall && (r1 != 32'd34);
    xreq  = syscall && (r1 == 32'd10);
    grise = go && !m_go_q;
    if (m_state == 2'd0 || m_state == 2'd1) begin
      if (xreq) m_state = 2'd3;
      else if (hreq) begin
        m_state = 2'd2;
        m_cnt   = m_cnt + 1'b1;
      end else m_state = step_mode ? 2'd1 : 2'd0;
    end else if (m_state == 2'd2 && grise) begin
      m_state = step_mode ? 2'd1 : 2'd0;
    end
    m_go_q   = go;
    m_step_q = step;
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_go_q = 1'b0; m_step_q = 1'b0; m_cnt = '0;
  endtask

  // Called just after a negedge; applies the edge, drives new inputs, predicts,
  // and returns at the next negedge with outputs settled.
  task automatic cycle(input logic sc, input logic [31:0] r, input logic g,
                       input logic s, input logic sm);
    @(posedge clk);
    model_edge();
    #1;
    syscall = sc; r1 = r; go = g; step = s; step_mode = sm;
    sb.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    syscall = 1'b0; go = 1'b0; step = 1'b0; step_mode = 1'b0; r1 = '0;
    pulse_clr();
    #1;
    checks++;
    if (state !== 2'd0 || halted !== 1'b0 || done !== 1'b0 || cpu_en !== 1'b1 || pause_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state got st=%0d h=%b d=%b en=%b cnt=%0d need st=0 h=0 d=0 en=1 cnt=0",
               state, halted, done, cpu_en, pause_cnt);
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL reset_run[%0d] got=%h need=%h", i, got, exp_o);
      end
    end
  endtask

  task automatic test_print();
    logic sc_t [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(sc_t[i], 32'd34, 1'b0, 1'b0, 1'b0);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL print[%0d] got=%h need=%h", i, got, exp_o);
      end
    end
  endtask

  task automatic test_pause();
    // go held high into the pause must not resume; only the later 0->1 edge does.
    logic sc_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic g_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(sc_t[i], 32'd5, g_t[i], 1'b0, 1'b0);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL pause[%0d] got=%h need=%h", i, got, exp_o);
      end
      if (i == 2) begin
        checks++;
        if (state !== 2'd2 || halted !== 1'b1 || cpu_en !== 1'b0) begin
          failures++;
          $display("FAIL pause_hold got st=%0d h=%b en=%b need st=2 h=1 en=0", state, halted, cpu_en);
        end
      end
    end
  endtask

  task automatic test_exit();
    logic g_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic s_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cycle(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
    got = obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin
      failures++;
      $display("FAIL exit_entry got=%h need=%h", got, exp_o);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'd0, g_t[i], s_t[i], i[0]);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o || cpu_en !== 1'b0) begin
        failures++;
        $display("FAIL exit_hold[%0d] got=%h need=%h", i, got, exp_o);
      end
    end
    // Asynchronous clear mid-cycle, well away from any clock edge.
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || done !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL exit_clr got st=%0d d=%b h=%b need st=0 d=0 h=0", state, done, halted);
    end
    clr = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_step();
    logic s_t [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   commits = 0;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    got = obs(); exp_o = sb.pop_front(); checks++;
    if (got !== exp_o) begin
      failures++;
      $display("FAIL step_enter got=%h need=%h", got, exp_o);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'd0, 1'b0, s_t[i], 1'b1);
      commits += int'(cpu_en);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL step[%0d] got=%h need=%h", i, got, exp_o);
      end
    end
    checks++;
    if (commits != 3) begin
      failures++;
      $display("FAIL step_presses commits=%0d need 3", commits);
    end
    commits = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      commits += int'(cpu_en);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL step_held[%0d] got=%h need=%h", i, got, exp_o);
      end
    end
    checks++;
    if (commits != 1) begin
      failures++;
      $display("FAIL step_held_count commits=%0d need 1", commits);
    end
  endtask

  task automatic test_step_halt();
    // Step edge with a halting syscall: no commit, enter PAUSE; step edges there are ignored.
    logic          sc_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic          s_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic          g_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic          sm_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [CW-1:0] cnt0;
    cnt0 = m_cnt;
    for (int i = 0; i < 7; i++) begin
      cycle(sc_t[i], 32'd7, g_t[i], s_t[i], sm_t[i]);
      got = obs(); exp_o = sb.pop_front(); checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL step_halt[%0d] got=%h need=%h", i, got, exp_o);
      end
      if (i == 2) begin
        checks++;
        if (state !== 2'd2 || pause_cnt !== cnt0 + 1'b1) begin
          failures++;
          $display("FAIL step_halt_pause got st=%0d cnt=%0d need st=2 cnt=%0d", state, pause_cnt, cnt0 + 1'b1);
        end
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    pulse_clr();
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 3; k++) begin
        cycle(k != 2, 32'd5, k == 1, 1'b0, 1'b0);
        got = obs(); exp_o = sb.pop_front(); checks++;
        if (got !== exp_o) begin
          failures++;
          $display("FAIL wrap[%0d.%0d] got=%h need=%h", p, k, got, exp_o);
        end
      end
      if (p == 14) begin
        checks++;
        if (pause_cnt !== 4'd15) begin
          failures++;
          $display("FAIL wrap_max got=%0d need=15", pause_cnt);
        end
      end
    end
    checks++;
    if (pause_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero got=%0d need=0", pause_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_print();
    test_pause();
    test_exit();
    test_step();
    test_step_halt();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d need 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
